// File: rtl/div_cfg_if.sv
// Configuration bus between the key-driven controller and the divider datapath.
// The controller is the master; the divider acknowledges each applied word with cfg_done.
interface div_cfg_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_done;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_done);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_done);
endinterface

// File: rtl/div_cfg_ctrl.sv
// Key-driven divider configuration controller: per-channel shadow ratios, boot load of
// defaults, and valid/ready + done delivery of committed ratios with a done timeout.
module div_cfg_ctrl #(
  parameter int CH_NUM  = 4,
  parameter int DIV_W   = 16,
  parameter int DIV_MIN = 2,
  parameter int DIV_MAX = 65535,
  parameter int DIV_DEF = 10,
  parameter int STEP    = 1,
  parameter int DONE_TO = 1024,
  localparam int CH_W   = $clog2(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_flag,
  div_cfg_if.master         cfg,
  output logic              busy,
  output logic [CH_W-1:0]   cur_ch,
  output logic [DIV_W-1:0]  cur_div,
  output logic [CH_NUM-1:0] dirty,
  output logic              err_timeout
);
  localparam int TO_W = (DONE_TO > 1) ? $clog2(DONE_TO) : 1;

  typedef enum logic [1:0] {BOOT = 2'd0, SEND = 2'd1, WAIT_DONE = 2'd2, IDLE = 2'd3} state_t;

  state_t              state_r, state_nxt;
  logic                cfg_valid_r, cfg_valid_nxt;
  logic [CH_W-1:0]     cfg_ch_r, cfg_ch_nxt;
  logic [DIV_W-1:0]    cfg_div_r, cfg_div_nxt;
  logic                busy_r;
  logic                boot_r, boot_nxt;
  logic [CH_W-1:0]     boot_idx_r, boot_idx_nxt;
  logic [TO_W-1:0]     timer_r, timer_nxt;
  logic [CH_W-1:0]     cur_ch_r, cur_ch_nxt;
  logic [DIV_W-1:0]    shadow_r [CH_NUM];
  logic [DIV_W-1:0]    shadow_nxt [CH_NUM];
  logic [CH_NUM-1:0]   dirty_r, dirty_nxt;
  logic                err_r, err_nxt;

  logic                accept_s, tmo_s, xfer_end_s, boot_last_s;
  logic [DIV_W:0]      sum_s;
  logic [DIV_W-1:0]    inc_s, dec_s;

  assign accept_s    = cfg_valid_r && cfg.cfg_ready;
  assign tmo_s       = (timer_r == TO_W'(DONE_TO - 1));
  assign xfer_end_s  = cfg.cfg_done || tmo_s;
  assign boot_last_s = (boot_idx_r == CH_W'(CH_NUM - 1));

  // Saturating edits computed one bit wider so the increment can never wrap.
  assign sum_s = {1'b0, cur_div} + (DIV_W+1)'(STEP);
  assign inc_s = (sum_s > (DIV_W+1)'(DIV_MAX)) ? DIV_W'(DIV_MAX) : sum_s[DIV_W-1:0];
  assign dec_s = ({1'b0, cur_div} < (DIV_W+1)'(DIV_MIN + STEP)) ? DIV_W'(DIV_MIN)
                                                                 : (cur_div - DIV_W'(STEP));

  assign cfg.cfg_valid = cfg_valid_r;
  assign cfg.cfg_ch    = cfg_ch_r;
  assign cfg.cfg_div   = cfg_div_r;
  assign busy          = busy_r;
  assign cur_ch        = cur_ch_r;
  assign cur_div       = shadow_r[cur_ch_r];
  assign dirty         = dirty_r;
  assign err_timeout   = err_r;

  // State and datapath registers; reset drops cfg_valid immediately and restarts boot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= BOOT;
      cfg_valid_r <= 1'b0;
      cfg_ch_r    <= '0;
      cfg_div_r   <= '0;
      busy_r      <= 1'b1;
      boot_r      <= 1'b1;
      boot_idx_r  <= '0;
      timer_r     <= '0;
      cur_ch_r    <= '0;
      dirty_r     <= '0;
      err_r       <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) shadow_r[i] <= DIV_W'(DIV_DEF);
    end else begin
      state_r     <= state_nxt;
      cfg_valid_r <= cfg_valid_nxt;
      cfg_ch_r    <= cfg_ch_nxt;
      cfg_div_r   <= cfg_div_nxt;
      busy_r      <= (state_nxt != IDLE);
      boot_r      <= boot_nxt;
      boot_idx_r  <= boot_idx_nxt;
      timer_r     <= timer_nxt;
      cur_ch_r    <= cur_ch_nxt;
      dirty_r     <= dirty_nxt;
      err_r       <= err_nxt;
      shadow_r    <= shadow_nxt;
    end
  end

  // Next-state selection; a timeout during boot advances exactly like a done.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      BOOT:      state_nxt = SEND;
      SEND:      if (accept_s) state_nxt = WAIT_DONE; else state_nxt = SEND;
      WAIT_DONE: begin
        if (xfer_end_s) begin
          if (boot_r && !boot_last_s) state_nxt = BOOT;
          else                        state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      IDLE:      if (key_flag == 4'b1000 && dirty_r[cur_ch_r]) state_nxt = SEND;
                 else state_nxt = IDLE;
      default:   state_nxt = BOOT;
    endcase
  end

  // Datapath updates; keys act only in IDLE and only when exactly one bit is set.
  always_comb begin
    cfg_valid_nxt = (state_nxt == SEND);
    cfg_ch_nxt    = cfg_ch_r;
    cfg_div_nxt   = cfg_div_r;
    boot_nxt      = boot_r;
    boot_idx_nxt  = boot_idx_r;
    timer_nxt     = timer_r;
    cur_ch_nxt    = cur_ch_r;
    dirty_nxt     = dirty_r;
    err_nxt       = err_r;
    shadow_nxt    = shadow_r;
    case (state_r)
      BOOT: begin
        cfg_ch_nxt  = boot_idx_r;
        cfg_div_nxt = DIV_W'(DIV_DEF);
      end
      SEND: begin
        if (accept_s) timer_nxt = '0;
        else          timer_nxt = timer_r;
      end
      WAIT_DONE: begin
        timer_nxt = timer_r + TO_W'(1);
        if (cfg.cfg_done) begin
          dirty_nxt[cfg_ch_r] = 1'b0;
          err_nxt             = 1'b0;
        end else if (tmo_s) begin
          err_nxt = 1'b1;
        end else begin
          err_nxt = err_r;
        end
        if (xfer_end_s && boot_r) begin
          if (boot_last_s) boot_nxt = 1'b0;
          else             boot_idx_nxt = boot_idx_r + CH_W'(1);
        end else begin
          boot_nxt = boot_r;
        end
      end
      IDLE: begin
        case (key_flag)
          4'b0001: cur_ch_nxt = cur_ch_r + CH_W'(1);
          4'b0010: begin
            shadow_nxt[cur_ch_r] = inc_s;
            if (inc_s != cur_div) dirty_nxt[cur_ch_r] = 1'b1;
            else                  dirty_nxt[cur_ch_r] = dirty_r[cur_ch_r];
          end
          4'b0100: begin
            shadow_nxt[cur_ch_r] = dec_s;
            if (dec_s != cur_div) dirty_nxt[cur_ch_r] = 1'b1;
            else                  dirty_nxt[cur_ch_r] = dirty_r[cur_ch_r];
          end
          4'b1000: begin
            if (dirty_r[cur_ch_r]) begin
              cfg_ch_nxt  = cur_ch_r;
              cfg_div_nxt = cur_div;
            end else begin
              cfg_ch_nxt  = cfg_ch_r;
            end
          end
          default: cur_ch_nxt = cur_ch_r;
        endcase
      end
      default: cfg_ch_nxt = cfg_ch_r;
    endcase
  end
endmodule

// File: tb/tb_div_cfg_ctrl.sv
// Directed bench for div_cfg_ctrl: expected config words are queued when stimulus is
// driven and popped when the controller presents a word that the divider accepts.
module tb_div_cfg_ctrl;
  localparam int DONE_TO = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_flag;
  logic        busy;
  logic [1:0]  cur_ch;
  logic [15:0] cur_div;
  logic [3:0]  dirty;
  logic        err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q [$];

  div_cfg_if #(.CH_W(2), .DIV_W(16)) bus ();

  div_cfg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_flag   (key_flag),
    .cfg        (bus.master),
    .busy       (busy),
    .cur_ch     (cur_ch),
    .cur_div    (cur_div),
    .dirty      (dirty),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] k);
    key_flag = k;
    tick();
    key_flag = 4'b0000;
  endtask

  // Waits for a word the divider will take on the next edge, compares it, then lets it go.
  task automatic wait_accept(input string tag);
    int n = 0;
    logic [17:0] exp;
    while (!(bus.cfg_valid === 1'b1 && bus.cfg_ready === 1'b1) && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, (n < 64), 1);
    check({tag, "_queued"}, (exp_q.size() > 0), 1);
    if (n < 64 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_ch"}, bus.cfg_ch, exp[17:16]);
      check({tag, "_div"}, bus.cfg_div, exp[15:0]);
    end
    tick();
    check({tag, "_valid_drop"}, bus.cfg_valid, 0);
  endtask

  task automatic xfer(input string tag);
    wait_accept(tag);
    tick();
    bus.cfg_done = 1'b1;
    tick();
    bus.cfg_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    key_flag = 4'b0000;
    bus.cfg_ready = 1'b0;
    bus.cfg_done = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.cfg_valid, 0);
    check("rst_ch", bus.cfg_ch, 0);
    check("rst_div", bus.cfg_div, 0);
    check("rst_busy", busy, 1);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_cur_div", cur_div, 10);
    check("rst_dirty", dirty, 0);
    check("rst_err", err_timeout, 0);

    // Boot: four default words in channel order
    rst = 1'b1;
    bus.cfg_ready = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back({c[1:0], 16'd10});
    for (int c = 0; c < 4; c++) xfer("boot");
    check("boot_busy", busy, 0);
    check("boot_dirty", dirty, 0);
    check("boot_err", err_timeout, 0);

    // Edit and commit with backpressure
    key(4'b0010); key(4'b0010); key(4'b0010); key(4'b0100);
    check("edit_div", cur_div, 12);
    check("edit_dirty", dirty, 4'b0001);
    bus.cfg_ready = 1'b0;
    exp_q.push_back({2'd0, 16'd12});
    key(4'b1000);
    check("commit_valid", bus.cfg_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", bus.cfg_valid, 1);
      check("hold_ch", bus.cfg_ch, 0);
      check("hold_div", bus.cfg_div, 12);
    end
    bus.cfg_ready = 1'b1;
    xfer("commit");
    check("commit_dirty", dirty, 0);

    // Low saturation
    for (int i = 0; i < 10; i++) key(4'b0100);
    check("dec_div", cur_div, 2);
    exp_q.push_back({2'd0, 16'd2});
    key(4'b1000);
    xfer("commit_min");
    key(4'b0100);
    check("min_div", cur_div, 2);
    check("min_dirty", dirty, 0);

    // High saturation on channel 1, key held for the whole climb and one extra cycle
    key(4'b0001);
    check("sel_ch1", cur_ch, 1);
    key_flag = 4'b0010;
    repeat (65526) tick();
    key_flag = 4'b0000;
    check("max_div", cur_div, 65535);
    key(4'b0010);
    check("max_nowrap", cur_div, 65535);
    check("max_dirty", dirty, 4'b0010);

    // Channel wrap, illegal keys, commit of clean channel
    key(4'b0001); key(4'b0001);
    check("ch3", cur_ch, 3);
    key(4'b0001);
    check("wrap_ch0", cur_ch, 0);
    for (int i = 0; i < 4; i++) key(4'b0001);
    check("wrap4_ch0", cur_ch, 0);
    key(4'b0011);
    check("multi_ch", cur_ch, 0);
    check("multi_div", cur_div, 2);
    key(4'b1000);
    check("clean_valid", bus.cfg_valid, 0);
    check("clean_busy", busy, 0);

    // Timeout with keys pressed while waiting for done
    key(4'b0010);
    exp_q.push_back({2'd0, 16'd3});
    key(4'b1000);
    wait_accept("tmo");
    for (int k = 1; k <= DONE_TO; k++) begin
      key_flag = (k == 10) ? 4'b0001 : ((k == 12) ? 4'b0010 : 4'b0000);
      tick();
      if (k == DONE_TO - 1) begin
        check("tmo_err_early", err_timeout, 0);
        check("tmo_busy_early", busy, 1);
      end
    end
    key_flag = 4'b0000;
    check("tmo_err", err_timeout, 1);
    check("tmo_busy", busy, 0);
    check("tmo_dirty", dirty, 4'b0011);
    check("wait_keys_ch", cur_ch, 0);
    check("wait_keys_div", cur_div, 3);
    exp_q.push_back({2'd0, 16'd3});
    key(4'b1000);
    xfer("recommit");
    check("recommit_err", err_timeout, 0);
    check("recommit_dirty", dirty, 4'b0010);

    // Reset in the middle of SEND
    key(4'b0010);
    bus.cfg_ready = 1'b0;
    key(4'b1000);
    check("pre_rst_valid", bus.cfg_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", bus.cfg_valid, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_div", cur_div, 10);
    check("mid_rst_dirty", dirty, 0);
    tick();
    rst = 1'b1;
    bus.cfg_ready = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back({c[1:0], 16'd10});
    for (int c = 0; c < 4; c++) xfer("reboot");
    check("reboot_busy", busy, 0);
    check("q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
